// File: rtl/e203_ifu_irbuf_pkg.sv
// Shared definitions for the IFU-to-EXU instruction buffer.
//   - Datapath widths (PC, instruction, register index).
//   - Packed entry bundle carried through the buffer and its width constant.
// Optional feature macro used by the top level: E203_IRBUF_BYPASS_EN.
package e203_ifu_irbuf_pkg;

    localparam int unsigned E203_PC_SIZE     = 32;
    localparam int unsigned E203_INSTR_SIZE  = 32;
    localparam int unsigned E203_RFIDX_WIDTH = 5;

    localparam int unsigned PC_W    = E203_PC_SIZE;
    localparam int unsigned IR_W    = E203_INSTR_SIZE;
    localparam int unsigned RFIDX_W = E203_RFIDX_WIDTH;

    // Five single-bit status flags travel with each instruction.
    localparam int unsigned E203_IRBUF_ENTRY_W = IR_W + PC_W + 2 * RFIDX_W + 5;

    typedef struct packed {
        logic [IR_W-1:0]    ir;
        logic [PC_W-1:0]    pc;
        logic               pc_vld;
        logic               misalgn;
        logic               buserr;
        logic               prdt_taken;
        logic               muldiv_b2b;
        logic [RFIDX_W-1:0] rs1idx;
        logic [RFIDX_W-1:0] rs2idx;
    } irbuf_entry_t;

endpackage

// File: rtl/e203_ifu_irbuf_if.sv
// Valid/ready instruction bundle link used on both sides of the buffer.
//   master: drives valid + payload, receives ready.
//   slave : receives valid + payload, drives ready.
// Payload: ir, pc, pc_vld, misalgn, buserr, prdt_taken, muldiv_b2b, rs1idx, rs2idx.
interface e203_ifu_irbuf_if;
    import e203_ifu_irbuf_pkg::*;

    logic               valid;
    logic               ready;
    logic [IR_W-1:0]    ir;
    logic [PC_W-1:0]    pc;
    logic               pc_vld;
    logic               misalgn;
    logic               buserr;
    logic               prdt_taken;
    logic               muldiv_b2b;
    logic [RFIDX_W-1:0] rs1idx;
    logic [RFIDX_W-1:0] rs2idx;

    modport master (
        output valid, ir, pc, pc_vld, misalgn, buserr, prdt_taken, muldiv_b2b, rs1idx, rs2idx,
        input  ready
    );

    modport slave (
        input  valid, ir, pc, pc_vld, misalgn, buserr, prdt_taken, muldiv_b2b, rs1idx, rs2idx,
        output ready
    );

endinterface

// File: rtl/e203_irbuf_fifo_ctrl.sv
// Generic circular-buffer pointer/counter controller.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the buffer, overrides push/pop
//   push, pop  : qualified write / read strobes
//   wp, rp     : write / read pointers (natural wrap, DEPTH is a power of two)
//   cnt        : occupied entries
//   full, empty: occupancy flags
module e203_irbuf_fifo_ctrl #(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic            pop,
    output logic [PtrW-1:0] wp,
    output logic [PtrW-1:0] rp,
    output logic [CntW-1:0] cnt,
    output logic            full,
    output logic            empty
);

    logic [PtrW-1:0] wp_q, wp_d;
    logic [PtrW-1:0] rp_q, rp_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wp_d = PtrW'(wp_q + 1'b1);
            if (pop)  rp_d = PtrW'(rp_q + 1'b1);
            unique case ({push, pop})
                2'b10:   cnt_d = CntW'(cnt_q + 1'b1);
                2'b01:   cnt_d = CntW'(cnt_q - 1'b1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // rst dominates flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign wp    = wp_q;
    assign rp    = rp_q;
    assign cnt   = cnt_q;
    assign full  = (cnt_q == CntW'(DEPTH));
    assign empty = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full))        else $error("irbuf push while full");
            assert (!(pop && empty))        else $error("irbuf pop while empty");
            assert (cnt_q <= CntW'(DEPTH))  else $error("irbuf count overflow");
        end
    end

endmodule

// File: rtl/e203_ifu_irbuf.sv
// Instruction buffer between IFU fetch and EXU decode/dispatch.
// Holds up to DEPTH IFU bundles in FIFO order and presents the oldest to the EXU.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   flush    : accepted pipeline flush, discards all entries (and a concurrent push)
//   ifu      : slave side of the IFU bundle link (i_* signals)
//   exu      : master side towards the EXU (o_* signals)
//   count    : occupied entries
// Optional: E203_IRBUF_BYPASS_EN makes an empty buffer forward the IFU bundle
// combinationally; otherwise the outputs come purely from stored entries.
module e203_ifu_irbuf
    import e203_ifu_irbuf_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    e203_ifu_irbuf_if.slave        ifu,
    e203_ifu_irbuf_if.master       exu,
    output logic [CntW-1:0]        count
);

    irbuf_entry_t    mem_q [DEPTH];
    irbuf_entry_t    in_entry;
    irbuf_entry_t    head_entry;
    logic [PtrW-1:0] wp, rp;
    logic [CntW-1:0] cnt;
    logic            full, empty;
    logic            push_acc, wr_en, pop;

    always_comb begin
        in_entry            = '0;
        in_entry.ir         = ifu.ir;
        in_entry.pc         = ifu.pc;
        in_entry.pc_vld     = ifu.pc_vld;
        in_entry.misalgn    = ifu.misalgn;
        in_entry.buserr     = ifu.buserr;
        in_entry.prdt_taken = ifu.prdt_taken;
        in_entry.muldiv_b2b = ifu.muldiv_b2b;
        in_entry.rs1idx     = ifu.rs1idx;
        in_entry.rs2idx     = ifu.rs2idx;
    end

    // Never depends on exu.ready: a full buffer refuses even when popping.
    assign ifu.ready = ~full & ~flush;
    assign push_acc  = ifu.valid & ifu.ready;

`ifdef E203_IRBUF_BYPASS_EN
    logic byp_take;

    assign exu.valid  = (~empty | ifu.valid) & ~flush;
    // Bundle consumed straight through: no storage write.
    assign byp_take   = empty & push_acc & exu.ready;
    assign wr_en      = push_acc & ~byp_take;
    assign pop        = ~empty & exu.valid & exu.ready;
    assign head_entry = empty ? in_entry : mem_q[rp];
`else
    assign exu.valid  = ~empty;
    assign wr_en      = push_acc;
    assign pop        = exu.valid & exu.ready;
    assign head_entry = mem_q[rp];
`endif

    e203_irbuf_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_fifo_ctrl (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (wr_en),
        .pop   (pop),
        .wp    (wp),
        .rp    (rp),
        .cnt   (cnt),
        .full  (full),
        .empty (empty)
    );

    // Storage is intentionally not reset; cnt gates its visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wp] <= in_entry;
        end
    end

    always_comb begin
        exu.ir         = head_entry.ir;
        exu.pc         = head_entry.pc;
        exu.pc_vld     = head_entry.pc_vld;
        exu.misalgn    = head_entry.misalgn;
        exu.buserr     = head_entry.buserr;
        exu.prdt_taken = head_entry.prdt_taken;
        exu.muldiv_b2b = head_entry.muldiv_b2b;
        exu.rs1idx     = head_entry.rs1idx;
        exu.rs2idx     = head_entry.rs2idx;
    end

    assign count = cnt;

endmodule

// File: tb/tb_e203_ifu_irbuf.sv
// Self-checking bench for e203_ifu_irbuf: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_e203_ifu_irbuf;
    import e203_ifu_irbuf_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CntW  = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic [CntW-1:0] count;

    e203_ifu_irbuf_if ifu_if ();
    e203_ifu_irbuf_if exu_if ();

    e203_ifu_irbuf #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .ifu   (ifu_if),
        .exu   (exu_if),
        .count (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    irbuf_entry_t model_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic irbuf_entry_t mk(input logic [31:0] pc, input logic [31:0] ir);
        irbuf_entry_t e;
        e.ir         = ir;
        e.pc         = pc;
        e.pc_vld     = ~pc[3];
        e.misalgn    = pc[2];
        e.buserr     = pc[4];
        e.prdt_taken = pc[5];
        e.muldiv_b2b = pc[6];
        e.rs1idx     = pc[6:2];
        e.rs2idx     = ~pc[6:2];
        return e;
    endfunction

    function automatic irbuf_entry_t ifu_entry();
        irbuf_entry_t e;
        e.ir         = ifu_if.ir;
        e.pc         = ifu_if.pc;
        e.pc_vld     = ifu_if.pc_vld;
        e.misalgn    = ifu_if.misalgn;
        e.buserr     = ifu_if.buserr;
        e.prdt_taken = ifu_if.prdt_taken;
        e.muldiv_b2b = ifu_if.muldiv_b2b;
        e.rs1idx     = ifu_if.rs1idx;
        e.rs2idx     = ifu_if.rs2idx;
        return e;
    endfunction

    function automatic irbuf_entry_t exu_entry();
        irbuf_entry_t e;
        e.ir         = exu_if.ir;
        e.pc         = exu_if.pc;
        e.pc_vld     = exu_if.pc_vld;
        e.misalgn    = exu_if.misalgn;
        e.buserr     = exu_if.buserr;
        e.prdt_taken = exu_if.prdt_taken;
        e.muldiv_b2b = exu_if.muldiv_b2b;
        e.rs1idx     = exu_if.rs1idx;
        e.rs2idx     = exu_if.rs2idx;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                         input logic ordy, input logic fl);
        irbuf_entry_t e;
        e = mk(pc, ir);
        ifu_if.valid      = v;
        ifu_if.ir         = e.ir;
        ifu_if.pc         = e.pc;
        ifu_if.pc_vld     = e.pc_vld;
        ifu_if.misalgn    = e.misalgn;
        ifu_if.buserr     = e.buserr;
        ifu_if.prdt_taken = e.prdt_taken;
        ifu_if.muldiv_b2b = e.muldiv_b2b;
        ifu_if.rs1idx     = e.rs1idx;
        ifu_if.rs2idx     = e.rs2idx;
        exu_if.ready      = ordy;
        flush             = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a FIFO of bundles updated on each clock edge.
    always @(posedge clk) begin : model
        int n;
        logic take, push, pop;
        irbuf_entry_t e;
        n = model_q.size();
        e = ifu_entry();
        if (rst || flush) begin
            model_q.delete();
        end else begin
            push = ifu_if.valid && (n != DEPTH);
            pop  = (n != 0) && exu_if.ready;
`ifdef E203_IRBUF_BYPASS_EN
            take = (n == 0) && ifu_if.valid && exu_if.ready;
`else
            take = 1'b0;
`endif
            if (!take) begin
                if (pop)  void'(model_q.pop_front());
                if (push) model_q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : compare
        int n;
        logic exp_valid;
        irbuf_entry_t exp_head;
        if (!rst) begin
            n = model_q.size();
`ifdef E203_IRBUF_BYPASS_EN
            exp_valid = !flush && (n != 0 || ifu_if.valid);
            exp_head  = (n != 0) ? model_q[0] : ifu_entry();
`else
            exp_valid = (n != 0);
            exp_head  = (n != 0) ? model_q[0] : '0;
`endif
            chk("cmp_count", 128'(count), 128'(n));
            chk("cmp_i_ready", 128'(ifu_if.ready), 128'((n != DEPTH) && !flush));
            chk("cmp_o_valid", 128'(exu_if.valid), 128'(exp_valid));
            if (exp_valid) chk("cmp_head", 128'(exu_entry()), 128'(exp_head));
        end
    end

    initial begin
        logic [31:0] got[$];
        int idx;
        logic acc;

        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_o_valid", 128'(exu_if.valid), 128'(0));
        chk("reset_i_ready", 128'(ifu_if.ready), 128'(1));
        chk("reset_count", 128'(count), 128'(0));

        // Single push, visible next cycle.
        drive(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t1_o_valid", 128'(exu_if.valid), 128'(1));
        chk("t1_o_ir", 128'(exu_if.ir), 128'(32'h0000_0013));
        chk("t1_o_pc", 128'(exu_if.pc), 128'(32'h8000_0000));
        chk("t1_count", 128'(count), 128'(1));
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("t1_drained", 128'(count), 128'(0));

        // Fill with o_ready low; third offer refused, head held.
        drive(1'b1, 32'h1000, 32'h1013, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h1004, 32'h1413, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h1008, 32'h1813, 1'b0, 1'b0);
        #1;
        chk("t2_count_full", 128'(count), 128'(2));
        chk("t2_i_ready", 128'(ifu_if.ready), 128'(0));
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t2_count_hold", 128'(count), 128'(2));
        chk("t2_head_hold", 128'(exu_if.pc), 128'(32'h1000));
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("t2_second", 128'(exu_if.pc), 128'(32'h1004));
        tick();
        chk("t2_drained", 128'(count), 128'(0));

        // Streaming across pointer wrap with alternating o_ready.
        idx = 0;
        for (int c = 0; c < 40 && got.size() < 6; c++) begin
            drive(idx < 6, 32'h2000 + 32'(4 * idx), 32'h13 + 32'(idx), (c % 2) == 1, 1'b0);
            #1;
            acc = ifu_if.valid && ifu_if.ready;
            if (exu_if.valid && exu_if.ready) got.push_back(exu_if.pc);
            tick();
            if (acc) idx++;
        end
        chk("t3_num_out", 128'(got.size()), 128'(6));
        for (int i = 0; i < got.size(); i++) begin
            chk("t3_order", 128'(got[i]), 128'(32'h2000 + 32'(4 * i)));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (3) tick();

        // Simultaneous push/pop at count 1.
        drive(1'b1, 32'h3000, 32'h3013, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3004, 32'h3413, 1'b1, 1'b0);
        #1;
        chk("t4_count_before", 128'(count), 128'(1));
        chk("t4_i_ready", 128'(ifu_if.ready), 128'(1));
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t4_count_after", 128'(count), 128'(1));
        chk("t4_head", 128'(exu_if.pc), 128'(32'h3004));
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        // Flush with concurrent push.
        drive(1'b1, 32'h3100, 32'h3113, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3104, 32'h3513, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h4000, 32'h4013, 1'b1, 1'b1);
        #1;
        chk("t5_i_ready_flush", 128'(ifu_if.ready), 128'(0));
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t5_count", 128'(count), 128'(0));
        chk("t5_o_valid", 128'(exu_if.valid), 128'(0));
        tick();
        chk("t5_o_valid_later", 128'(exu_if.valid), 128'(0));

        // Empty buffer with o_ready high: bypass vs one-cycle latency.
        drive(1'b1, 32'h5000, 32'h5013, 1'b1, 1'b0);
        #1;
`ifdef E203_IRBUF_BYPASS_EN
        chk("t6_byp_o_valid", 128'(exu_if.valid), 128'(1));
        chk("t6_byp_o_pc", 128'(exu_if.pc), 128'(32'h5000));
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("t6_byp_count", 128'(count), 128'(0));
`else
        chk("t6_o_valid_same", 128'(exu_if.valid), 128'(0));
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("t6_o_valid_next", 128'(exu_if.valid), 128'(1));
        chk("t6_o_pc_next", 128'(exu_if.pc), 128'(32'h5000));
        chk("t6_count_next", 128'(count), 128'(1));
        tick();
        chk("t6_drained", 128'(count), 128'(0));
`endif

        // Reset mid-operation behaves like a flush.
        drive(1'b1, 32'h6000, 32'h6013, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h6004, 32'h6413, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h6008, 32'h6813, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t7_count", 128'(count), 128'(0));
        chk("t7_o_valid", 128'(exu_if.valid), 128'(0));
        chk("t7_i_ready", 128'(ifu_if.ready), 128'(1));
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
